// File: rtl/reg_dump_reader_if.sv
`default_nettype none
// ============================================================================
//  Module  : reg_dump_reader_if
//  Purpose : Bundles the control, register-file read port and streaming
//            output signals of the register dump reader.
//            master : drives start/abort/range, read data, out_ready
//            slave  : the reader itself (drives rf_raddr and the out_* word)
//  Rev     : 1.0  initial release
// ============================================================================
interface reg_dump_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] first_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] rf_raddr;
    logic [DATA_WIDTH-1:0] rf_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, first_addr, last_addr, rf_rdata, out_ready,
        input  rf_raddr, out_valid, out_data, out_addr, out_last, busy, done
    );

    modport slave (
        input  start, abort, first_addr, last_addr, rf_rdata, out_ready,
        output rf_raddr, out_valid, out_data, out_addr, out_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module  : reg_dump_reader
//  Purpose : Walks an inclusive register index range on a dedicated
//            register-file read port and streams each word with its index
//            over a valid/ready output (one word per cycle without stalls).
//  Ports   : clk, rst (sync, active-high)
//            bus (slave) : start/abort/first_addr/last_addr control,
//                          rf_raddr/rf_rdata read port,
//                          out_valid/out_ready/out_data/out_addr/out_last,
//                          busy, done status
//  Rev     : 1.0  initial release
// ============================================================================
module reg_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    reg_dump_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_LAST = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] last_q;
    logic [ADDR_WIDTH-1:0] raddr;

    // One-entry output register: a snapshot of the word taken at capture.
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_flag_q;
    logic                  done_q;

    logic                  load;
    logic                  take_range;
    logic                  final_accept;
    logic                  done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load         = 1'b0;
        take_range   = 1'b0;
        final_accept = 1'b0;
        done_next    = 1'b0;
        raddr        = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    take_range = 1'b1;
                    // An inverted range is an empty dump: just report done.
                    if (bus.first_addr <= bus.last_addr) begin
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                raddr = ptr;
                if (!valid_q || bus.out_ready) begin
                    load = 1'b1;
                    // Ending on equality means ptr never has to wrap.
                    if (ptr == last_q) begin
                        state_next = WAIT_LAST;
                    end
                end
            end
            WAIT_LAST: begin
                if (valid_q && bus.out_ready) begin
                    final_accept = 1'b1;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything except reset, including a start in IDLE.
        if (bus.abort) begin
            state_next   = IDLE;
            load         = 1'b0;
            take_range   = 1'b0;
            final_accept = 1'b0;
            done_next    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            last_q      <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            last_flag_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= done_next;
            if (bus.abort) begin
                valid_q     <= 1'b0;
                last_flag_q <= 1'b0;
            end else begin
                if (take_range) begin
                    ptr    <= bus.first_addr;
                    last_q <= bus.last_addr;
                end
                if (load) begin
                    valid_q     <= 1'b1;
                    data_q      <= bus.rf_rdata;
                    addr_q      <= ptr;
                    last_flag_q <= (ptr == last_q);
                    if (ptr != last_q) begin
                        ptr <= ptr + ADDR_WIDTH'(1);
                    end
                end
                if (final_accept) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    // rf_raddr depends on state and ptr only, never on out_ready.
    assign bus.rf_raddr  = raddr;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_last  = last_flag_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_reg_dump_reader
//  Purpose : Directed self-checking bench for reg_dump_reader with a
//            behavioural register file model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_reg_dump_reader;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    reg_dump_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    assign bus.rf_rdata = rf[bus.rf_raddr];

    reg_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.first_addr = '0;
        bus.last_addr = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.out_valid, bus.out_last, bus.busy, bus.done});
        end
        checks++;
        if (bus.out_data !== 32'h0 || bus.out_addr !== 5'h0 || bus.rf_raddr !== 5'h0) begin
            failures++;
            $display("FAIL reset_data: got data=%h addr=%h raddr=%h expected all 0",
                     bus.out_data, bus.out_addr, bus.rf_raddr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b valid=%b expected 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_full_dump();
        bus.first_addr = 5'd0;
        bus.last_addr  = 5'd31;
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.rf_raddr !== 5'd0) begin
            failures++;
            $display("FAIL full_start: got busy=%b valid=%b raddr=%h expected 1 0 00",
                     bus.busy, bus.out_valid, bus.rf_raddr);
        end
        for (int k = 0; k < 32; k++) begin
            logic [31:0] exp_data;
            exp_data = (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);
            tick();
            checks++;
            if ({bus.out_valid, bus.out_addr, bus.out_data, bus.out_last, bus.done}
                !== {1'b1, 5'(k), exp_data, (k == 31), 1'b0}) begin
                failures++;
                $display("FAIL full_word%0d: got v=%b a=%h d=%h l=%b done=%b expected v=1 a=%h d=%h l=%b done=0",
                         k, bus.out_valid, bus.out_addr, bus.out_data, bus.out_last, bus.done,
                         5'(k), exp_data, (k == 31));
            end
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL full_done: got valid=%b done=%b busy=%b expected 0 1 0",
                     bus.out_valid, bus.done, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL full_done_pulse: got done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int         exp_idx;
        logic       seen_done;
        pat       = 4'b1001;   // ready sequence 1,0,0,1 repeating
        exp_idx   = 4;
        seen_done = 1'b0;
        bus.first_addr = 5'd4;
        bus.last_addr  = 5'd7;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            bus.out_ready = pat[cyc % 4];
            if (bus.done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if ({bus.out_addr, bus.out_data, bus.out_last}
                    !== {exp_idx[4:0], rf[exp_idx], (exp_idx == 7)}) begin
                    failures++;
                    $display("FAIL bp_word: cycle %0d got a=%h d=%h l=%b expected a=%h d=%h l=%b",
                             cyc, bus.out_addr, bus.out_data, bus.out_last,
                             exp_idx[4:0], rf[exp_idx], (exp_idx == 7));
                end
                if (bus.out_ready) exp_idx++;
            end
            tick();
        end
        checks++;
        if (seen_done !== 1'b1 || exp_idx != 8) begin
            failures++;
            $display("FAIL bp_count: got done_seen=%b next_idx=%0d expected 1 8", seen_done, exp_idx);
        end
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_snapshot();
        bus.out_ready  = 1'b0;
        bus.first_addr = 5'd5;
        bus.last_addr  = 5'd6;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 5'd5, 32'h1000_0005}) begin
            failures++;
            $display("FAIL snap_capture: got v=%b a=%h d=%h expected v=1 a=05 d=10000005",
                     bus.out_valid, bus.out_addr, bus.out_data);
        end
        rf[5] = 32'hDEAD_BEEF;
        tick();
        tick();
        checks++;
        if ({bus.out_valid, bus.out_addr, bus.out_data, bus.out_last}
            !== {1'b1, 5'd5, 32'h1000_0005, 1'b0}) begin
            failures++;
            $display("FAIL snap_hold: got v=%b a=%h d=%h l=%b expected v=1 a=05 d=10000005 l=0",
                     bus.out_valid, bus.out_addr, bus.out_data, bus.out_last);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_addr, bus.out_data, bus.out_last}
            !== {1'b1, 5'd6, 32'h1000_0006, 1'b1}) begin
            failures++;
            $display("FAIL snap_word6: got v=%b a=%h d=%h l=%b expected v=1 a=06 d=10000006 l=1",
                     bus.out_valid, bus.out_addr, bus.out_data, bus.out_last);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL snap_done: got done=%b valid=%b expected 1 0", bus.done, bus.out_valid);
        end
        rf[5] = 32'h1000_0005;
        tick();
    endtask

    task automatic test_edge_ranges();
        bus.out_ready  = 1'b1;
        bus.first_addr = 5'd31;
        bus.last_addr  = 5'd31;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_addr, bus.out_data, bus.out_last}
            !== {1'b1, 5'd31, 32'h1000_001F, 1'b1}) begin
            failures++;
            $display("FAIL edge_single: got v=%b a=%h d=%h l=%b expected v=1 a=1f d=1000001f l=1",
                     bus.out_valid, bus.out_addr, bus.out_data, bus.out_last);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL edge_single_done: got done=%b valid=%b expected 1 0", bus.done, bus.out_valid);
        end
        // Back-to-back: start in the cycle where done is high.
        bus.first_addr = 5'd2;
        bus.last_addr  = 5'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.rf_raddr !== 5'd2 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_start: got busy=%b raddr=%h done=%b expected 1 02 0",
                     bus.busy, bus.rf_raddr, bus.done);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_addr, bus.out_last} !== {1'b1, 5'd2, 1'b0}) begin
            failures++;
            $display("FAIL b2b_word2: got v=%b a=%h l=%b expected 1 02 0",
                     bus.out_valid, bus.out_addr, bus.out_last);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_addr, bus.out_data, bus.out_last}
            !== {1'b1, 5'd3, 32'h1000_0003, 1'b1}) begin
            failures++;
            $display("FAIL b2b_word3: got v=%b a=%h d=%h l=%b expected 1 03 10000003 1",
                     bus.out_valid, bus.out_addr, bus.out_data, bus.out_last);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: got done=%b expected 1", bus.done);
        end
        tick();
        // Inverted range: empty dump.
        bus.first_addr = 5'd9;
        bus.last_addr  = 5'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_done: got done=%b busy=%b valid=%b expected 1 0 0",
                     bus.done, bus.busy, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_after: got done=%b valid=%b busy=%b expected 0 0 0",
                     bus.done, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_abort();
        bus.out_ready  = 1'b1;
        bus.first_addr = 5'd0;
        bus.last_addr  = 5'd31;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 5'(k), rf[k]}) begin
                failures++;
                $display("FAIL abort_word%0d: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                         k, bus.out_valid, bus.out_addr, bus.out_data, 5'(k), rf[k]);
            end
            // A start during the dump (with a different range) must be ignored.
            bus.start = (k == 3);
            if (k == 3) begin
                bus.first_addr = 5'd20;
                bus.last_addr  = 5'd25;
            end
            if (k == 10) bus.out_ready = 1'b0;
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_addr} !== {1'b1, 5'd10}) begin
            failures++;
            $display("FAIL abort_stall: got v=%b a=%h expected 1 0a", bus.out_valid, bus.out_addr);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.out_valid, bus.busy, bus.done, bus.out_last} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_clear: got valid/busy/done/last=%b expected 0000",
                     {bus.out_valid, bus.busy, bus.done, bus.out_last});
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_nodone: got done=%b valid=%b expected 0 0", bus.done, bus.out_valid);
        end
        // abort together with start in IDLE: abort wins.
        bus.out_ready  = 1'b1;
        bus.first_addr = 5'd0;
        bus.last_addr  = 5'd1;
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_start: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_start_novalid: got valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready  = 1'b1;
        bus.first_addr = 5'd0;
        bus.last_addr  = 5'd31;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.done} !== 4'b0000
            || bus.out_data !== 32'h0 || bus.out_addr !== 5'h0 || bus.rf_raddr !== 5'h0) begin
            failures++;
            $display("FAIL rst_mid: got v=%b l=%b busy=%b done=%b d=%h a=%h raddr=%h expected all 0",
                     bus.out_valid, bus.out_last, bus.busy, bus.done,
                     bus.out_data, bus.out_addr, bus.rf_raddr);
        end
        bus.first_addr = 5'd2;
        bus.last_addr  = 5'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_addr, bus.out_data, bus.out_last}
            !== {1'b1, 5'd2, 32'h1000_0002, 1'b0}) begin
            failures++;
            $display("FAIL rst_word2: got v=%b a=%h d=%h l=%b expected 1 02 10000002 0",
                     bus.out_valid, bus.out_addr, bus.out_data, bus.out_last);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_addr, bus.out_last} !== {1'b1, 5'd3, 1'b1}) begin
            failures++;
            $display("FAIL rst_word3: got v=%b a=%h l=%b expected 1 03 1",
                     bus.out_valid, bus.out_addr, bus.out_last);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_done: got done=%b busy=%b expected 1 0", bus.done, bus.busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
        end
        test_reset();
        test_full_dump();
        test_backpressure();
        test_snapshot();
        test_edge_ranges();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential read-out engine for the RISC-V core's register file. On a start pulse it walks a contiguous register index range on a dedicated register-file read port and streams each word, with its index, over a valid/ready output interface. It is used by the debug/trace path to dump architectural state without stalling the core's own read ports. Throughput is one register per cycle when the consumer never stalls.

## Interface
- DATA_WIDTH, 32, register word width
- ADDR_WIDTH, 5, register index width (NUM_REGS = 2^ADDR_WIDTH)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  cancel the dump in progress; highest priority after rst
- first_addr  in  ADDR_WIDTH  first index to dump; sampled with start
- last_addr  in  ADDR_WIDTH  last index to dump, inclusive; sampled with start
- rf_raddr  out  ADDR_WIDTH  index driven to the register-file read port
- rf_rdata  in  DATA_WIDTH  combinational read data for rf_raddr, same cycle
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_data  out  DATA_WIDTH  register value
- out_addr  out  ADDR_WIDTH  register index of out_data
- out_last  out  1  out_data is the final word of the dump
- busy  out  1  high in RUN and WAIT_LAST
- done  out  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE, RUN, WAIT_LAST. Registers: ptr, last_q, one-entry output register (valid, data, addr, last).
- IDLE: rf_raddr = 0. On start: latch ptr <= first_addr, last_q <= last_addr.
  - first_addr <= last_addr: go to RUN.
  - first_addr > last_addr: empty dump; stay IDLE, pulse done next cycle, no output word.
- RUN: rf_raddr = ptr. Load condition: !out_valid || out_ready. On load: out_data <= rf_rdata, out_addr <= ptr, out_last <= (ptr == last_q), out_valid <= 1.
  - On load with ptr == last_q: go to WAIT_LAST. Otherwise ptr <= ptr + 1.
  - No load: ptr holds and rf_raddr holds.
- WAIT_LAST: no new loads. When out_valid && out_ready: out_valid <= 0, done <= 1 for one cycle, go to IDLE.
- In RUN, an accept with no new load (not possible by construction) never occurs. An accept together with a new load replaces the word. out_valid stays 1.
- Held word stability: while out_valid && !out_ready, out_data, out_addr, and out_last do not change. This holds even if the core writes that register. The value is a snapshot taken at capture.
- Capture sees the pre-write value for a core write to ptr in the same cycle, because the register file updates on the edge.
- Index 0 streams whatever the register file returns (zero). There is no special case.
- ptr arithmetic is ADDR_WIDTH bits. last_addr = 2^ADDR_WIDTH-1 terminates on equality, so ptr never wraps.
- start while busy: ignored, including its first/last addresses.
- abort (any state): next cycle state = IDLE, out_valid = 0, out_last = 0, done = 0. A word pending at abort is discarded. abort together with start in IDLE: abort wins, no dump.
- rst: same effect as abort, plus all registers cleared.

## Timing
- Reset values: rf_raddr 0, out_valid 0, out_data 0, out_addr 0, out_last 0, busy 0, done 0.
- Start sampled at edge E0. busy is high from E0. rf_raddr = first_addr during cycle E0–E1. First word is valid after E1.
- With out_ready held high, a dump of N words gives out_valid continuously after E1..EN. The last word is accepted at edge E(N+1). done is high during the cycle after E(N+1). busy falls at E(N+1).
- Empty range: done is high for the cycle after E0, busy stays 0.
- Back-to-back dumps: start is accepted in the cycle in which done is high (state is IDLE).
- No combinational path from out_ready to rf_raddr is required. rf_raddr is a function of state and ptr only.

## Test plan
- Full dump: preload r[i] = 0x1000_0000+i (r0 = 0), first 0, last 31, out_ready = 1. Expect 32 words over 32 consecutive cycles, addr 0..31 with matching data, out_last only on addr 31, and done one cycle after acceptance.
- Backpressure: range 4..7, out_ready toggling 1,0,0,1,… Expect each word held stable while stalled, no duplicates or skips, and order 4,5,6,7.
- Snapshot: range 5..6, hold out_ready = 0 after word 5 is captured, and the core writes r5 = 0xDEAD_BEEF. Expect out_data to keep the old r5. Expect word 6 after release.
- Edge ranges: first = last = 31 gives one word with out_last = 1. first = 9, last = 3 gives no out_valid and a done pulse one cycle after start.
- Abort/start-while-busy: start 0..31, assert abort at word 10 while it is stalled. Expect out_valid = 0 next cycle, no done, busy = 0. A start pulse during a dump must not restart or alter the range.
- Reset mid-dump: rst during RUN. Expect all outputs 0 next cycle. A fresh dump of 2..3 afterwards completes normally.
